mulnu_seq_approx: RTL and testbench



---
 rtl/mulnu_pkg.sv | 19 +
 rtl/mulnu_pp_gen.sv | 26 ++
 rtl/mulnu_seq_approx.sv | 101 ++++++++++
 tb/tb_mulnu_seq_approx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mulnu_pkg.sv
// Shared types and helpers for the sequential shift-add approximate multiplier.
// Supports products up to MAX_PROD_W bits wide, so operands up to 32 bits.
package mulnu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int MAX_PROD_W = 64;

  // Bits at or above column 'trunc' are set, up to the 2*width product size.
  function automatic logic [MAX_PROD_W-1:0] trunc_mask(input int width, input int trunc);
    logic [MAX_PROD_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_PROD_W; b++) begin
      if (b >= trunc && b < 2 * width) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mulnu_pp_gen.sv
// Combinational partial-product generator: (A << i), with the low TRUNC
// columns cleared when approximate mode is selected.
module mulnu_pp_gen
  import mulnu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0]   a_lat,
  input  logic [IDX_W-1:0]   idx,
  input  logic               approx_en_lat,
  output logic [2*WIDTH-1:0] pp
);

  localparam logic [MAX_PROD_W-1:0] FULL_MASK   = trunc_mask(WIDTH, TRUNC);
  localparam logic [2*WIDTH-1:0]    APPROX_MASK = FULL_MASK[2*WIDTH-1:0];

  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    shifted = {{WIDTH{1'b0}}, a_lat} << idx;
    pp      = approx_en_lat ? (shifted & APPROX_MASK) : shifted;
  end

endmodule

// File: rtl/mulnu_seq_approx.sv
// Sequential shift-add unsigned multiplier with exact/truncated modes,
// valid/ready handshakes on both sides and a saturating completion counter.
module mulnu_seq_approx
  import mulnu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] O,
  output logic [CNT_W-1:0]   op_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;
  logic               approx_lat;
  logic [2*WIDTH-1:0] acc;
  logic [IDX_W-1:0]   idx;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_next;

  mulnu_pp_gen #(
    .WIDTH(WIDTH),
    .TRUNC(TRUNC),
    .IDX_W(IDX_W)
  ) u_pp_gen (
    .a_lat        (a_lat),
    .idx          (idx),
    .approx_en_lat(approx_lat),
    .pp           (pp)
  );

  assign in_ready = (state == IDLE);

  always_comb begin
    acc_next = acc;
    if (b_lat[idx]) acc_next = acc + pp;
  end

  // One multiplier bit per BUSY cycle; the final sum goes straight into O.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_lat      <= '0;
      b_lat      <= '0;
      approx_lat <= 1'b0;
      acc        <= '0;
      idx        <= '0;
      O          <= '0;
      out_valid  <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat      <= A;
            b_lat      <= B;
            approx_lat <= approx_en;
            acc        <= '0;
            idx        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            O         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (op_count != {CNT_W{1'b1}}) op_count <= op_count + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mulnu_seq_approx.sv
// Randomised self-checking bench for mulnu_seq_approx, with an arithmetic
// reference model and a second instance using a 2-bit counter for saturation.
module tb_mulnu_seq_approx;

  localparam int WIDTH = 8;
  localparam int TRUNC = 4;
  localparam int PW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [WIDTH-1:0] A, B;
  logic          approx_en;
  logic          out_ready;
  logic          in_ready, out_valid;
  logic [PW-1:0] O;
  logic [15:0]   op_count;
  logic          in_ready2, out_valid2;
  logic [PW-1:0] O2;
  logic [1:0]    op_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int exp_cnt2 = 0;

  always #5 clk = ~clk;

  mulnu_seq_approx #(.WIDTH(WIDTH), .TRUNC(TRUNC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .O(O), .op_count(op_count)
  );

  mulnu_seq_approx #(.WIDTH(WIDTH), .TRUNC(TRUNC), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .A(A), .B(B), .approx_en(approx_en), .out_valid(out_valid2),
    .out_ready(out_ready), .O(O2), .op_count(op_count2)
  );

  // Sum of shifted multiplicands, each with its value below 2^TRUNC dropped when approximate.
  function automatic longint refMul(input longint a, input longint b, input bit ap);
    longint sum, term;
    sum = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (((b >> i) & 1) == 1) begin
        term = a * (longint'(1) << i);
        if (ap) term = term - (term % (longint'(1) << TRUNC));
        sum = sum + term;
      end
    end
    return sum;
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full transaction: accept, measure latency, optionally backpressure, handshake.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit ap, input int hold);
    longint exp_o;
    int k;
    exp_o = refMul(a, b, ap);
    out_ready = (hold == 0);
    checkOutput("in_ready_idle", longint'(in_ready), 1);
    in_valid = 1'b1; A = a; B = b; approx_en = ap;
    @(posedge clk); #1;
    in_valid = 1'b0; A = WIDTH'($urandom); B = WIDTH'($urandom); approx_en = 1'($urandom);
    checkOutput("in_ready_busy", longint'(in_ready), 0);
    k = 0;
    while (k < WIDTH + 4 && !out_valid) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("latency", longint'(k), longint'(WIDTH));
    checkOutput("out_valid", longint'(out_valid), 1);
    checkOutput("product", longint'(O), exp_o);
    checkOutput("product_cnt2", longint'(O2), exp_o);
    if (ap) checkOutput("trunc_low_zero", longint'(O[TRUNC-1:0]), 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); A = WIDTH'($urandom); B = WIDTH'($urandom);
      @(posedge clk); #1;
      checkOutput("bp_O_stable", longint'(O), exp_o);
      checkOutput("bp_valid", longint'(out_valid), 1);
      checkOutput("bp_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt  = (exp_cnt == 65535) ? exp_cnt : exp_cnt + 1;
    exp_cnt2 = (exp_cnt2 == 3) ? exp_cnt2 : exp_cnt2 + 1;
    checkOutput("hs_valid_low", longint'(out_valid), 0);
    checkOutput("hs_in_ready", longint'(in_ready), 1);
    checkOutput("hs_O_retained", longint'(O), exp_o);
    checkOutput("op_count", longint'(op_count), longint'(exp_cnt));
    checkOutput("op_count_sat", longint'(op_count2), longint'(exp_cnt2));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; approx_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_O", longint'(O), 0);
    checkOutput("rst_op_count", longint'(op_count), 0);
    checkOutput("rst_in_ready", longint'(in_ready), 1);

    applyStimulus(8'hFF, 8'hFF, 1'b0, 0);
    checkOutput("exact_ff_const", longint'(O), 64'hFE01);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    checkOutput("approx_ff_const", longint'(O), 64'hFDD0);
    applyStimulus(8'h01, 8'h80, 1'b1, 0);
    applyStimulus(8'h03, 8'h01, 1'b1, 0);
    applyStimulus(8'hA5, 8'h3C, 1'b0, 5);

    // Abort in the middle of BUSY.
    in_valid = 1'b1; A = 8'h12; B = 8'h34; approx_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0; exp_cnt2 = 0;
    checkOutput("abort_out_valid", longint'(out_valid), 0);
    checkOutput("abort_O", longint'(O), 0);
    checkOutput("abort_op_count", longint'(op_count), 0);
    checkOutput("abort_op_count2", longint'(op_count2), 0);
    checkOutput("abort_in_ready", longint'(in_ready), 1);
    applyStimulus(8'h12, 8'h34, 1'b0, 0);
    checkOutput("after_abort_const", longint'(O), 64'h03A8);

    for (int n = 0; n < 4; n++) applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0);
    checkOutput("sat_value", longint'(op_count2), 3);

    for (int n = 0; n < 25; n++)
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
